// File: rtl/imem_pkg.sv
// +-----------------------------------------------------------------------+
// | Module   : imem_pkg                                                   |
// | Purpose  : Shared types and constants for the instruction responder   |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

  // Index type is sized for the default 16-bit byte-address fetch port.
  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_IDX_W  = IMEM_ADDR_W - 1;
  localparam int IMEM_DATA_W = 16;

  localparam logic [IMEM_DATA_W-1:0] IMEM_FAULT_DATA = '0;

  typedef logic [IMEM_IDX_W-1:0] imem_idx_t;

  typedef struct packed {
    logic      valid;
    imem_idx_t idx;
    logic      fault;
  } imem_stage_t;

  function automatic logic imem_in_range(input imem_idx_t idx, input int unsigned aw);
    return (idx >> aw) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_word_array.sv
// +-----------------------------------------------------------------------+
// | Module   : imem_word_array                                            |
// | Purpose  : Synchronous 1R1W word RAM with write-first read bypass     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module imem_word_array #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the read register is reset; the storage itself keeps its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_responder.sv
// +-----------------------------------------------------------------------+
// | Module   : imem_fetch_responder                                       |
// | Purpose  : Fixed-latency in-order instruction fetch responder         |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic              i_pc_rd,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_pc_rddata,
  output logic              o_pc_rddata_valid,
  output logic              o_pc_fault,
  input  logic              i_ld_wr,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data
);

  localparam int c_AW   = $clog2(DEPTH_WORDS);
  localparam int c_NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;

  imem_idx_t         w_pc_idx;
  imem_idx_t         w_ld_idx;
  imem_stage_t       w_req;
  imem_stage_t       w_final_in;
  logic              w_advance;
  logic              w_accept;
  logic              w_rd_en;
  logic              w_ld_en;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              r_out_valid;
  logic              r_out_fault;
  logic              w_unused;

  assign w_pc_idx  = i_pc_addr[ADDR_W-1:1];
  assign w_ld_idx  = i_ld_addr[ADDR_W-1:1];
  assign w_advance = !i_stall && !i_flush;
  assign w_accept  = i_pc_rd && w_advance;
  assign w_ld_en   = i_ld_wr && imem_in_range(w_ld_idx, c_AW);

  always_comb begin
    w_req       = '0;
    w_req.valid = w_accept;
    w_req.idx   = w_pc_idx;
    w_req.fault = !imem_in_range(w_pc_idx, c_AW);
  end

  // Stages 1..LATENCY-1 live here; the output register acts as the final stage.
  if (LATENCY > 1) begin : g_pipe
    imem_stage_t r_pipe [c_NSTG];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < c_NSTG; k++) begin
          r_pipe[k] <= '0;
        end
      end else if (i_flush) begin
        for (int k = 0; k < c_NSTG; k++) begin
          r_pipe[k].valid <= 1'b0;
        end
      end else if (!i_stall) begin
        r_pipe[0].valid <= w_accept;
        if (w_accept) begin
          r_pipe[0].idx   <= w_req.idx;
          r_pipe[0].fault <= w_req.fault;
        end
        for (int k = 1; k < c_NSTG; k++) begin
          r_pipe[k] <= r_pipe[k-1];
        end
      end
    end

    assign w_final_in = r_pipe[c_NSTG-1];
  end else begin : g_no_pipe
    assign w_final_in = w_req;
  end

  assign w_rd_en = w_advance && w_final_in.valid && !w_final_in.fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_fault <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (!i_stall) begin
      r_out_valid <= w_final_in.valid;
      if (w_final_in.valid) begin
        r_out_fault <= w_final_in.fault;
      end
    end
  end

  imem_word_array #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (DATA_W),
    .AW     (c_AW)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_ld_en),
    .i_waddr (w_ld_idx[c_AW-1:0]),
    .i_wdata (i_ld_data),
    .i_re    (w_rd_en),
    .i_raddr (w_final_in.idx[c_AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // Faulted reads hold the fault flag, so the substituted data persists until the next completion.
  assign o_pc_rddata       = r_out_fault ? DATA_W'(IMEM_FAULT_DATA) : w_ram_rdata;
  assign o_pc_rddata_valid = r_out_valid;
  assign o_pc_fault        = r_out_fault;

  assign w_unused = ^{i_pc_addr[0], i_ld_addr[0], w_final_in.idx};

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
// +-----------------------------------------------------------------------+
// | Module   : tb_imem_fetch_responder                                    |
// | Purpose  : Self-checking bench with a queue-based reference model     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_imem_fetch_responder;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_rd;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] rddata;
  logic              rddata_valid;
  logic              fault;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  always #5 clk = ~clk;

  imem_fetch_responder #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_pc_addr         (pc_addr),
    .i_pc_rd           (pc_rd),
    .i_stall           (stall),
    .i_flush           (flush),
    .o_pc_rddata       (rddata),
    .o_pc_rddata_valid (rddata_valid),
    .o_pc_fault        (fault),
    .i_ld_wr           (ld_wr),
    .i_ld_addr         (ld_addr),
    .i_ld_data         (ld_data)
  );

  // Reference model: a list of outstanding reads, each counting unstalled cycles to completion.
  typedef struct {
    int rem;
    int idx;
  } req_t;

  req_t              q[$];
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              e_valid;
  logic              e_fault;
  logic [DATA_W-1:0] e_data;
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic model_clear();
    q.delete();
    e_valid = 1'b0;
    e_fault = 1'b0;
    e_data  = '0;
  endtask

  task automatic idle_inputs();
    pc_rd = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    ld_wr = 1'b0;
  endtask

  task automatic step();
    int   pidx;
    int   lidx;
    req_t r;
    @(posedge clk);
    pidx = int'(pc_addr[ADDR_W-1:1]);
    lidx = int'(ld_addr[ADDR_W-1:1]);
    if (!reset_n) begin
      model_clear();
    end else begin
      if (ld_wr && lidx < DEPTH) m_mem[lidx] = ld_data;
      if (flush) begin
        q.delete();
        e_valid = 1'b0;
      end else if (!stall) begin
        if (pc_rd) q.push_back('{rem: LAT, idx: pidx});
        e_valid = 1'b0;
        for (int i = 0; i < q.size(); i++) q[i].rem = q[i].rem - 1;
        if (q.size() > 0 && q[0].rem == 0) begin
          r       = q.pop_front();
          e_valid = 1'b1;
          e_fault = (r.idx >= DEPTH);
          e_data  = (r.idx >= DEPTH) ? '0 : m_mem[r.idx];
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pc_addr = '0;
    ld_addr = '0;
    ld_data = '0;
    idle_inputs();
    step();
    step();
    n_checks++;
    if (rddata_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", rddata_valid);
    end
    n_checks++;
    if (rddata !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0000", rddata);
    end
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_fault: got %b want 0", fault);
    end
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_wr   = 1'b1;
      ld_addr = ADDR_W'(i * 2);
      ld_data = DATA_W'($urandom);
      step();
    end
    idle_inputs();
    step();
    n_checks++;
    if (rddata_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_no_valid: got %b want 0", rddata_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [3] = '{16'h0000, 16'h0002, 16'h0004};
    logic [DATA_W-1:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic              ev [5]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DATA_W-1:0] ed [5]    = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h3333};
    for (int i = 0; i < 3; i++) begin
      ld_wr = 1'b1; ld_addr = addrs[i]; ld_data = words[i];
      step();
    end
    ld_wr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pc_rd   = (c < 3);
      pc_addr = (c < 3) ? addrs[c] : '0;
      step();
      n_checks++;
      if (rddata_valid !== ev[c]) begin
        n_fail++; $display("FAIL b2b_valid c%0d: got %b want %b", c, rddata_valid, ev[c]);
      end
      if (ev[c]) begin
        n_checks++;
        if (rddata !== ed[c]) begin
          n_fail++; $display("FAIL b2b_data c%0d: got %h want %h", c, rddata, ed[c]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_odd_and_range();
    logic [ADDR_W-1:0] addrs [2] = '{16'h0003, 16'h2000};
    logic [DATA_W-1:0] ed    [2] = '{16'h2222, 16'h0000};
    logic              ef    [2] = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      pc_rd = 1'b1; pc_addr = addrs[t];
      step();
      pc_rd = 1'b0;
      step();
      n_checks++;
      if (rddata_valid !== 1'b1 || rddata !== ed[t] || fault !== ef[t]) begin
        n_fail++;
        $display("FAIL addr_%h: got v=%b d=%h f=%b want v=1 d=%h f=%b",
                 addrs[t], rddata_valid, rddata, fault, ed[t], ef[t]);
      end
    end
    step();
    n_checks++;
    if (rddata_valid !== 1'b0 || rddata !== 16'h0000 || fault !== 1'b1) begin
      n_fail++; $display("FAIL range_hold: got v=%b d=%h f=%b want v=0 d=0000 f=1",
                         rddata_valid, rddata, fault);
    end
  endtask

  task automatic test_stall();
    int n_resp = 0;
    logic [DATA_W-1:0] first_d = '0;
    pc_rd = 1'b1; pc_addr = 16'h0004;
    step();
    pc_addr = 16'h0000;
    step();
    stall = 1'b1; pc_addr = 16'h0002;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (rddata_valid !== 1'b1 || rddata !== 16'h3333) begin
        n_fail++; $display("FAIL stall_hold c%0d: got v=%b d=%h want v=1 d=3333", c, rddata_valid, rddata);
      end
    end
    stall = 1'b0; pc_rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rddata_valid === 1'b1) begin
        if (n_resp == 0) first_d = rddata;
        n_resp++;
      end
    end
    n_checks++;
    if (n_resp != 1 || first_d !== 16'h1111) begin
      n_fail++; $display("FAIL stall_release: got %0d resp d=%h want 1 resp d=1111", n_resp, first_d);
    end
  endtask

  task automatic test_flush();
    int n_resp;
    for (int rep = 0; rep < 2; rep++) begin
      n_resp = 0;
      pc_rd = 1'b1; pc_addr = 16'h0000;
      step();
      pc_addr = 16'h0002;
      step();
      pc_addr = 16'h0004; flush = 1'b1; stall = (rep == 1);
      step();
      idle_inputs();
      n_resp += int'(rddata_valid === 1'b1);
      for (int c = 0; c < 3; c++) begin
        step();
        n_resp += int'(rddata_valid === 1'b1);
      end
      n_checks++;
      if (n_resp != 0) begin
        n_fail++; $display("FAIL flush_rep%0d: got %0d responses want 0", rep, n_resp);
      end
    end
    pc_rd = 1'b1; pc_addr = 16'h0004;
    step();
    pc_rd = 1'b0;
    step();
    n_checks++;
    if (rddata_valid !== 1'b1 || rddata !== 16'h3333) begin
      n_fail++; $display("FAIL after_flush: got v=%b d=%h want v=1 d=3333", rddata_valid, rddata);
    end
  endtask

  task automatic test_collision();
    pc_rd = 1'b1; pc_addr = 16'h000A;
    step();
    pc_rd = 1'b0;
    ld_wr = 1'b1; ld_addr = 16'h000A; ld_data = 16'hBEEF;
    step();
    ld_wr = 1'b0;
    n_checks++;
    if (rddata_valid !== 1'b1 || rddata !== 16'hBEEF) begin
      n_fail++; $display("FAIL collision: got v=%b d=%h want v=1 d=beef", rddata_valid, rddata);
    end
  endtask

  task automatic test_reset_inflight();
    int n_resp = 0;
    pc_rd = 1'b1; pc_addr = 16'h0000;
    step();
    pc_addr = 16'h0002;
    step();
    pc_addr = 16'h0004;
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (rddata_valid !== 1'b0 || rddata !== '0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: got v=%b d=%h f=%b want all 0", rddata_valid, rddata, fault);
    end
    idle_inputs();
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_resp += int'(rddata_valid === 1'b1);
    end
    n_checks++;
    if (n_resp != 0) begin
      n_fail++; $display("FAIL reset_drop: got %0d responses want 0", n_resp);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      pc_rd   = ($urandom_range(0, 9) < 7);
      stall   = ($urandom_range(0, 9) < 2);
      flush   = ($urandom_range(0, 19) == 0);
      pc_addr = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(16'h2000, 16'hFFFF))
                                              : ADDR_W'($urandom_range(0, 63));
      ld_wr   = ($urandom_range(0, 2) == 0);
      ld_addr = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(16'h2000, 16'hFFFF))
                                              : ADDR_W'($urandom_range(0, 63));
      ld_data = DATA_W'($urandom);
      step();
      n_checks++;
      if (rddata_valid !== e_valid || rddata !== e_data || fault !== e_fault) begin
        n_fail++;
        $display("FAIL random c%0d: got v=%b d=%h f=%b want v=%b d=%h f=%b",
                 c, rddata_valid, rddata, fault, e_valid, e_data, e_fault);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_odd_and_range();
    test_stall();
    test_flush();
    test_collision();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder that serves the fetch stage's read port (word-aligned byte address plus read strobe). It holds the program in an on-chip word array and returns read data in order, after a fixed latency, with a valid strobe. A separate load port initialises or patches the program. Pipeline stall and branch flush inputs hold or squash in-flight reads.

Parameters:
ADDR_W, 16, byte-address width of the fetch port.
DATA_W, 16, instruction word width.
DEPTH_WORDS, 4096, number of words in the array (power of two, at most 2^(ADDR_W-1)).
LATENCY, 2, cycles from an accepted read to its response (legal range 1..4).

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
i_pc_addr  in  ADDR_W  fetch byte address; bit 0 ignored.
i_pc_rd  in  1  fetch read request.
i_stall  in  1  pipeline stall; freezes the response pipeline.
i_flush  in  1  branch squash; kills every in-flight read.
o_pc_rddata  out  DATA_W  returned instruction word.
o_pc_rddata_valid  out  1  o_pc_rddata is valid this cycle.
o_pc_fault  out  1  the returned read was out of range; qualified by valid.
i_ld_wr  in  1  load-port write strobe.
i_ld_addr  in  ADDR_W  load-port byte address; bit 0 ignored.
i_ld_data  in  DATA_W  load-port write data.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - o_pc_rddata=0, o_pc_rddata_valid=0, o_pc_fault=0.
  - All pipeline valid bits cleared.
  - Array contents are not reset.
  - A reset in mid-operation discards all in-flight reads. No response is produced for them after reset is released.
- Word index: idx = addr[ADDR_W-1:1].
  - A read is in range when idx < DEPTH_WORDS.
  - An out-of-range read returns data 0 with o_pc_fault=1.
- Pipeline:
  - A LATENCY-deep shift register. Each stage holds {valid, idx, fault}.
  - Accept condition: i_pc_rd=1, i_stall=0, i_flush=0. An accepted read enters stage 1.
  - The array is read synchronously on entry to the final stage.
  - Response: o_pc_rddata_valid=1 exactly LATENCY cycles after acceptance, in issue order.
  - Throughput: one read per cycle.
- Stall (i_stall=1):
  - No acceptance.
  - All stages and all outputs hold their values, including o_pc_rddata_valid.
  - The read data is not re-sampled from the array.
- Flush (i_flush=1):
  - All stage valid bits and o_pc_rddata_valid clear on the next edge.
  - The request presented in the same cycle is dropped.
  - Flush overrides stall.
- Output register:
  - o_pc_rddata_valid drops to 0 in any unstalled cycle with no completing read.
  - o_pc_rddata keeps its last value when not valid.
- Load port:
  - i_ld_wr=1 writes i_ld_data to array[idx] at the edge.
  - Out-of-range loads are ignored.
  - Loads are accepted regardless of stall or flush.
- Same-cycle collision: when a load and the final-stage array read hit the same index in the same cycle, the read returns the NEW data (write-first).
- Request address and data are never X-propagated into state when i_pc_rd=0. Stage idx registers load only on acceptance.

Decomposition:
- Shared package imem_pkg:
  - typedef imem_idx_t (word index).
  - typedef imem_stage_t {valid, idx, fault}.
  - Constant IMEM_FAULT_DATA = 0.
- One sub-module: imem_word_array, a DEPTH_WORDS x DATA_W synchronous single-read/single-write RAM with write-first bypass.
- The pipeline and control logic stay in the top module.

Test Plan:
- Back-to-back reads: load words 0x1111, 0x2222, 0x3333 at byte addresses 0x0000, 0x0002, 0x0004. Issue i_pc_rd on 3 consecutive cycles with LATENCY=2 -> valid high on cycles 3, 4, 5 with data 0x1111, 0x2222, 0x3333 in order.
- Odd address: read at byte address 0x0003 -> returns 0x2222, fault=0.
- Out of range: DEPTH_WORDS=4096, read at byte address 0x2000 (idx 4096) -> data 0x0000 and fault=1 after LATENCY cycles.
- Stall: issue a read, then hold i_stall=1 for 3 cycles while the response is valid -> o_pc_rddata_valid and o_pc_rddata stay constant across the stall. Exactly one response is seen after the stall releases.
- Flush: issue 2 reads, then pulse i_flush with a third read present. Repeat with i_stall=1 also asserted -> no valid responses for any of the three. The next read after the flush returns normally after LATENCY cycles.
- Collision and reset:
  - Load 0xBEEF to idx 5 in the cycle its read reaches the final stage -> returns 0xBEEF.
  - Assert reset_n=0 with 2 reads in flight -> outputs 0 immediately. No response appears after reset is released.
